// File: rtl/btn_press_decoder.sv
// btn_press_decoder: conditions one raw pushbutton into a debounced level plus
// one-cycle press / release / long-press / click events and a press counter.
module btn_press_decoder #(
    parameter int DEBOUNCE_CYCLES   = 1250000,
    parameter int LONG_PRESS_CYCLES = 125000000,
    parameter int COUNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_in,
    output logic               btn_level,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_press,
    output logic               click_pulse,
    output logic [COUNT_W-1:0] press_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    localparam logic [1:0] S_RELEASED = 2'd0;
    localparam logic [1:0] S_PRESSED  = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;

    logic               sync0_q, sync1_q;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               level_q, level_d;
    logic [1:0]         state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;
    logic               click_q, click_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               rise, fall;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= btn_in;
            sync1_q <= sync0_q;
        end
    end

    // Stability counter: level flips only after DEBOUNCE_CYCLES disagreeing samples
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (sync1_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = sync1_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Edges of the debounced level, aligned with the edge that updates it
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Press classifier; a fall on the threshold edge counts as a click
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        count_d    = count_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        click_d    = 1'b0;
        case (state_q)
            S_RELEASED: begin
                if (rise) begin
                    state_d    = S_PRESSED;
                    hold_cnt_d = '0;
                    press_d    = 1'b1;
                    count_d    = count_q + COUNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (fall) begin
                    state_d   = S_RELEASED;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_HELD;
                    long_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_HELD: begin
                if (fall) begin
                    state_d   = S_RELEASED;
                    release_d = 1'b1;
                end
            end
            default: state_d = S_RELEASED;
        endcase
    end

    // State, counters and registered event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q   <= '0;
            level_q    <= 1'b0;
            state_q    <= S_RELEASED;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            click_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            level_q    <= level_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            click_q    <= click_d;
            count_q    <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign click_pulse   = click_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_btn_press_decoder.sv
// Directed bench for btn_press_decoder with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
// Inputs change 1 time unit after a rising edge, so they are first sampled on the
// next edge; a clean transition then shows on btn_level after the 6th tick.
module tb_btn_press_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       btn_level, press_pulse, release_pulse, long_press, click_pulse;
    logic [7:0] press_count;

    int cmp = 0;
    int err = 0;

    // Pulse event counters and width / X monitors, sampled on the falling edge
    int n_press = 0, n_rel = 0, n_long = 0, n_click = 0;
    int wide_err = 0, x_seen = 0;
    logic [3:0] prev_p = '0;

    btn_press_decoder #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10),
        .COUNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .click_pulse  (click_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [3:0] cur;
        cur = {press_pulse, release_pulse, long_press, click_pulse};
        if ($isunknown({btn_level, cur, press_count})) x_seen++;
        if ((cur & prev_p) != 4'b0) wide_err++;
        prev_p = cur;
        if (press_pulse === 1'b1)   n_press++;
        if (release_pulse === 1'b1) n_rel++;
        if (long_press === 1'b1)    n_long++;
        if (click_pulse === 1'b1)   n_click++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        btn_in = 1'b1;
        rst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp++;
            if ({btn_level, press_pulse, release_pulse, long_press, click_pulse, press_count} !== 13'd0) begin
                err++;
                $display("FAIL reset_outputs cycle %0d: got %b want 0", i,
                         {btn_level, press_pulse, release_pulse, long_press, click_pulse, press_count});
            end
        end
        rst = 1'b0;
        tick(5);
        cmp++;
        if ({btn_level, press_pulse} !== 2'b00) begin
            err++; $display("FAIL reset_early_press: got %b want 00", {btn_level, press_pulse});
        end
        tick();
        cmp++;
        if ({btn_level, press_pulse, press_count} !== {2'b11, 8'd1}) begin
            err++; $display("FAIL reset_held_press: got %b/%0d want 11/1", {btn_level, press_pulse}, press_count);
        end
        tick();
        cmp++;
        if (press_pulse !== 1'b0) begin
            err++; $display("FAIL reset_press_width: got %b want 0", press_pulse);
        end
        // quick release: still a click
        btn_in = 1'b0;
        tick(6);
        cmp++;
        if ({btn_level, release_pulse, click_pulse, long_press} !== 4'b0110) begin
            err++; $display("FAIL reset_release: got %b want 0110",
                            {btn_level, release_pulse, click_pulse, long_press});
        end
        tick(4);
    endtask

    task automatic test_bounce();
        int p0;
        logic [4:0] pat;
        pat = 5'b10110;
        p0  = n_press;
        for (int i = 4; i >= 0; i--) begin
            btn_in = pat[i];
            tick();
        end
        btn_in = 1'b1;
        tick(5);
        cmp++;
        if ((n_press - p0) !== 0 || btn_level !== 1'b0) begin
            err++; $display("FAIL bounce_no_pulse: got %0d pulses level %b want 0/0", n_press - p0, btn_level);
        end
        tick();
        cmp++;
        if ({btn_level, press_pulse, press_count} !== {2'b11, 8'd2}) begin
            err++; $display("FAIL bounce_press: got %b/%0d want 11/2", {btn_level, press_pulse}, press_count);
        end
        tick(3);
        cmp++;
        if ((n_press - p0) !== 1) begin
            err++; $display("FAIL bounce_count: got %0d want 1", n_press - p0);
        end
        btn_in = 1'b0;
        tick(12);
    endtask

    task automatic test_short_click();
        int l0;
        l0 = n_long;
        btn_in = 1'b1;
        tick(6);
        cmp++;
        if (press_pulse !== 1'b1) begin
            err++; $display("FAIL click_press: got %b want 1", press_pulse);
        end
        tick(2);
        btn_in = 1'b0;
        tick(5);
        cmp++;
        if ({release_pulse, click_pulse} !== 2'b00) begin
            err++; $display("FAIL click_early: got %b want 00", {release_pulse, click_pulse});
        end
        tick();
        cmp++;
        if ({btn_level, release_pulse, click_pulse} !== 3'b011) begin
            err++; $display("FAIL click_release: got %b want 011", {btn_level, release_pulse, click_pulse});
        end
        tick(12);
        cmp++;
        if ((n_long - l0) !== 0) begin
            err++; $display("FAIL click_no_long: got %0d want 0", n_long - l0);
        end
    endtask

    task automatic test_long_press();
        int l0, c0;
        l0 = n_long;
        c0 = n_click;
        btn_in = 1'b1;
        tick(6);
        cmp++;
        if (press_pulse !== 1'b1) begin
            err++; $display("FAIL long_press_start: got %b want 1", press_pulse);
        end
        tick(9);
        cmp++;
        if (long_press !== 1'b0) begin
            err++; $display("FAIL long_early: got %b want 0", long_press);
        end
        tick();
        cmp++;
        if (long_press !== 1'b1) begin
            err++; $display("FAIL long_at_threshold: got %b want 1", long_press);
        end
        tick(20);
        btn_in = 1'b0;
        tick(6);
        cmp++;
        if ({btn_level, release_pulse, click_pulse} !== 3'b010) begin
            err++; $display("FAIL long_release: got %b want 010", {btn_level, release_pulse, click_pulse});
        end
        tick(4);
        cmp++;
        if ((n_long - l0) !== 1 || (n_click - c0) !== 0) begin
            err++; $display("FAIL long_once: got long %0d click %0d want 1/0", n_long - l0, n_click - c0);
        end
    endtask

    task automatic test_coincident();
        int l0;
        l0 = n_long;
        btn_in = 1'b1;
        tick(6);
        cmp++;
        if (press_pulse !== 1'b1) begin
            err++; $display("FAIL coinc_press: got %b want 1", press_pulse);
        end
        // fall lands 10 edges after the press edge, i.e. on the threshold edge
        tick(4);
        btn_in = 1'b0;
        tick(6);
        cmp++;
        if ({release_pulse, click_pulse, long_press} !== 3'b110) begin
            err++; $display("FAIL coinc_release: got %b want 110", {release_pulse, click_pulse, long_press});
        end
        tick(12);
        cmp++;
        if ((n_long - l0) !== 0) begin
            err++; $display("FAIL coinc_no_long: got %0d want 0", n_long - l0);
        end
    endtask

    task automatic test_wrap();
        int p0, r0;
        rst = 1'b1;
        btn_in = 1'b0;
        tick();
        rst = 1'b0;
        cmp++;
        if (press_count !== 8'd0) begin
            err++; $display("FAIL wrap_clear: got %0d want 0", press_count);
        end
        tick(4);
        p0 = n_press;
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b1;
            tick(8);
            btn_in = 1'b0;
            tick(8);
            if (i == 254) begin
                cmp++;
                if (press_count !== 8'd255 || (n_press - p0) !== 255) begin
                    err++; $display("FAIL wrap_255: got count %0d pulses %0d want 255/255",
                                    press_count, n_press - p0);
                end
            end
        end
        cmp++;
        if (press_count !== 8'd0) begin
            err++; $display("FAIL wrap_zero: got %0d want 0", press_count);
        end
        cmp++;
        if (x_seen !== 0) begin
            err++; $display("FAIL no_x: got %0d X samples want 0", x_seen);
        end
        // reset in the middle of a press discards it silently
        btn_in = 1'b1;
        tick(8);
        cmp++;
        if ({btn_level, press_count} !== {1'b1, 8'd1}) begin
            err++; $display("FAIL midpress_setup: got %b/%0d want 1/1", btn_level, press_count);
        end
        r0 = n_rel;
        rst = 1'b1;
        btn_in = 1'b0;
        tick();
        rst = 1'b0;
        cmp++;
        if ({btn_level, press_count} !== 9'd0) begin
            err++; $display("FAIL midpress_reset: got %b/%0d want 0/0", btn_level, press_count);
        end
        tick(12);
        cmp++;
        if ((n_rel - r0) !== 0) begin
            err++; $display("FAIL midpress_no_release: got %0d want 0", n_rel - r0);
        end
    endtask

    task automatic test_pulse_width();
        cmp++;
        if (wide_err !== 0) begin
            err++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_err);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_short_click();
        test_long_press();
        test_coincident();
        test_wrap();
        test_pulse_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
